// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-state encoding for the fetch unit, decoder and bench.
package isa_pkg;

  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] DONE_CODE = 9'b011_111_111;
  localparam logic [2:0] OP_BRANCH = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: one synchronous write port, one combinational read port,
// every entry cleared synchronously on reset.
module jump_lut #(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Program counter / fetch unit: steps the PC through instruction ROM, takes
// branches through the jump LUT and stops when the decoder reports Done.
module instr_fetch #(
  parameter int INSTR_W = isa_pkg::INSTR_W,
  parameter int PC_W    = 10,
  parameter int LUT_AW  = 6,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  output logic [PC_W-1:0]    Imem_addr,
  input  logic [INSTR_W-1:0] Imem_rdata,
  output logic [INSTR_W-1:0] Mach_code,
  output logic               Valid,
  input  logic               Jen,
  input  logic [7:0]         Jptr,
  input  logic               BranchCond,
  input  logic               Halt_in,
  input  logic               Lut_we,
  input  logic [LUT_AW-1:0]  Lut_waddr,
  input  logic [PC_W-1:0]    Lut_wdata,
  output logic               Done,
  output logic [CNT_W-1:0]   Cycle_cnt
);

  import isa_pkg::*;

  fetch_state_t      state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PC_W-1:0]   lut_rdata;
  logic              lut_we_gated;
  logic              unused_jptr_hi;

  // The table is only reprogrammable while the program is not executing.
  assign lut_we_gated   = Lut_we && (state_reg != RUN);
  assign unused_jptr_hi = ^Jptr[7:LUT_AW];

  jump_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_jump_lut (
    .clk   (Clk),
    .srst  (Reset),
    .we    (lut_we_gated),
    .waddr (Lut_waddr),
    .wdata (Lut_wdata),
    .raddr (Jptr[LUT_AW-1:0]),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (Start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        // Counts the halting cycle too; saturates instead of wrapping.
        if (!(&cnt_reg)) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (Halt_in) begin
          state_next = HALT;
        end else if (Jen && BranchCond) begin
          pc_next = lut_rdata;
        end else begin
          pc_next = pc_reg + PC_W'(1);
        end
      end
      HALT: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = '0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign Imem_addr = pc_reg;
  assign Mach_code = Imem_rdata;
  assign Valid     = (state_reg == RUN);
  assign Done      = (state_reg == HALT);
  assign Cycle_cnt = cnt_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus hand sequences
// for halt-on-DONE, mid-run reset, and PC wrap / counter saturation on a small build.
module tb_instr_fetch;
  import isa_pkg::*;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 6;
  localparam int CNT_W  = 16;
  localparam int NV     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] mach_code;
  logic               valid;
  logic               jen;
  logic [7:0]         jptr;
  logic               bcond;
  logic               halt_in;
  logic               halt_drv;
  logic               model_on;
  logic               lut_we;
  logic [LUT_AW-1:0]  lut_waddr;
  logic [PC_W-1:0]    lut_wdata;
  logic               done;
  logic [CNT_W-1:0]   cycle_cnt;

  // Small build: 4-bit PC, 4-bit counter.
  logic               start1;
  logic [3:0]         addr1;
  logic [INSTR_W-1:0] rdata1;
  logic [INSTR_W-1:0] mach1;
  logic               valid1;
  logic               done1;
  logic [3:0]         cnt1;
  logic               zero1;
  logic [7:0]         zero8;
  logic [1:0]         zero2;
  logic [3:0]         zero4;

  logic [INSTR_W-1:0] rom [2**PC_W];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];
  assign halt_in    = model_on ? (valid && (mach_code == DONE_CODE)) : halt_drv;
  assign rdata1     = {5'b0, addr1};
  assign zero1      = 1'b0;
  assign zero8      = 8'd0;
  assign zero2      = 2'd0;
  assign zero4      = 4'd0;

  instr_fetch #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst), .Start(start),
    .Imem_addr(imem_addr), .Imem_rdata(imem_rdata), .Mach_code(mach_code),
    .Valid(valid), .Jen(jen), .Jptr(jptr), .BranchCond(bcond), .Halt_in(halt_in),
    .Lut_we(lut_we), .Lut_waddr(lut_waddr), .Lut_wdata(lut_wdata),
    .Done(done), .Cycle_cnt(cycle_cnt)
  );

  instr_fetch #(.PC_W(4), .LUT_AW(2), .CNT_W(4)) dut_small (
    .Clk(clk), .Reset(rst), .Start(start1),
    .Imem_addr(addr1), .Imem_rdata(rdata1), .Mach_code(mach1),
    .Valid(valid1), .Jen(zero1), .Jptr(zero8), .BranchCond(zero1), .Halt_in(zero1),
    .Lut_we(zero1), .Lut_waddr(zero2), .Lut_wdata(zero4),
    .Done(done1), .Cycle_cnt(cnt1)
  );

  typedef struct {
    logic            start;
    logic            we;
    logic [5:0]      waddr;
    logic [9:0]      wdata;
    logic            halt;
    logic            jen;
    logic            bc;
    logic [7:0]      jptr;
    logic [9:0]      exp_addr;
    logic            exp_valid;
    logic            exp_done;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t vecs [NV];

  task automatic put(input int idx, input int st, input int we, input int wa, input int wd,
                     input int h, input int j, input int b, input int jp,
                     input int ea, input int ev, input int ed, input int ec);
    vecs[idx].start     = st[0];
    vecs[idx].we        = we[0];
    vecs[idx].waddr     = wa[5:0];
    vecs[idx].wdata     = wd[9:0];
    vecs[idx].halt      = h[0];
    vecs[idx].jen       = j[0];
    vecs[idx].bc        = b[0];
    vecs[idx].jptr      = jp[7:0];
    vecs[idx].exp_addr  = ea[9:0];
    vecs[idx].exp_valid = ev[0];
    vecs[idx].exp_done  = ed[0];
    vecs[idx].exp_cnt   = ec[15:0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    halt_drv = 1'b0; jen = 1'b0; bcond = 1'b0; jptr = 8'd0;
  endtask

  task automatic check_state(input string tag, input int ea, input int ev, input int ed, input int ec);
    chk({tag, "_addr"},  32'(imem_addr), 32'(ea));
    chk({tag, "_valid"}, 32'(valid),     32'(ev));
    chk({tag, "_done"},  32'(done),      32'(ed));
    chk({tag, "_cnt"},   32'(cycle_cnt), 32'(ec));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**PC_W; i++) rom[i] = 9'((i * 37 + 5) & 9'h1FF);
    model_on = 1'b0;
    start1   = 1'b0;
    idle_inputs();
    rst = 1'b1;

    // row: start we waddr wdata halt jen bc jptr | addr valid done cnt
    put( 0, 0, 1, 3,  40, 0, 0, 0, 8'h00,   0, 0, 0, 0);
    put( 1, 1, 0, 0,   0, 0, 0, 0, 8'h00,   0, 0, 0, 0);
    put( 2, 0, 0, 0,   0, 0, 0, 0, 8'h00,   0, 1, 0, 0);
    put( 3, 0, 0, 0,   0, 0, 0, 0, 8'h00,   1, 1, 0, 1);
    put( 4, 0, 0, 0,   0, 0, 1, 1, 8'h03,   2, 1, 0, 2);
    put( 5, 0, 0, 0,   0, 0, 0, 0, 8'h00,  40, 1, 0, 3);
    put( 6, 0, 0, 0,   0, 0, 1, 0, 8'h03,  41, 1, 0, 4);
    put( 7, 1, 1, 3,  99, 0, 0, 0, 8'h00,  42, 1, 0, 5);
    put( 8, 0, 0, 0,   0, 0, 1, 1, 8'hC3,  43, 1, 0, 6);
    put( 9, 0, 0, 0,   0, 1, 1, 1, 8'h03,  40, 1, 0, 7);
    put(10, 0, 1, 5, 200, 1, 1, 1, 8'h03,  40, 0, 1, 8);
    put(11, 1, 0, 0,   0, 0, 0, 0, 8'h00,  40, 0, 1, 8);
    put(12, 0, 0, 0,   0, 0, 1, 1, 8'h05,   0, 1, 0, 0);
    put(13, 0, 0, 0,   0, 0, 1, 1, 8'h03, 200, 1, 0, 1);
    put(14, 0, 0, 0,   0, 0, 0, 0, 8'h00,  40, 1, 0, 2);
    put(15, 0, 0, 0,   0, 0, 0, 0, 8'h00,  41, 1, 0, 3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      start     = vecs[i].start;
      lut_we    = vecs[i].we;
      lut_waddr = vecs[i].waddr;
      lut_wdata = vecs[i].wdata;
      halt_drv  = vecs[i].halt;
      jen       = vecs[i].jen;
      bcond     = vecs[i].bc;
      jptr      = vecs[i].jptr;
      #1;
      $display("row %0d: addr=%0d valid=%0d done=%0d cnt=%0d", i, imem_addr, valid, done, cycle_cnt);
      check_state($sformatf("row%0d", i), int'(vecs[i].exp_addr), int'(vecs[i].exp_valid),
                  int'(vecs[i].exp_done), int'(vecs[i].exp_cnt));
      chk($sformatf("row%0d_mach", i), 32'(mach_code), 32'(rom[vecs[i].exp_addr]));
    end

    // Halt on DONE_CODE fetched at address 5, decoder model drives Halt_in.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) rom[i] = '0;
    rom[5]   = DONE_CODE;
    model_on = 1'b1;
    start    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      $display("halt_seq cycle %0d: addr=%0d valid=%0d", k, imem_addr, valid);
      chk($sformatf("halt_seq_addr%0d", k), 32'(imem_addr), 32'(k));
      chk($sformatf("halt_seq_valid%0d", k), 32'(valid), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      $display("halt_seq halted: addr=%0d done=%0d cnt=%0d", imem_addr, done, cycle_cnt);
      check_state($sformatf("halted%0d", k), 5, 0, 1, 6);
    end
    model_on = 1'b0;

    // Reset mid-RUN at PC=7 with a taken branch pending; LUT must come back cleared.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lut_we = 1'b1; lut_waddr = 6'd3; lut_wdata = 10'd40; start = 1'b1;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 20 && imem_addr != 10'd7; k++) @(negedge clk);
    chk("reach_pc7", 32'(imem_addr), 32'd7);
    rst = 1'b1; jen = 1'b1; bcond = 1'b1; jptr = 8'd3;
    @(negedge clk);
    rst = 1'b0; jen = 1'b0; bcond = 1'b0;
    #1;
    $display("mid_reset: addr=%0d valid=%0d done=%0d cnt=%0d", imem_addr, valid, done, cycle_cnt);
    check_state("mid_reset", 0, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; jen = 1'b1; bcond = 1'b1; jptr = 8'd3;
    #1;
    check_state("post_reset_run", 0, 1, 0, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    $display("lut_cleared: addr=%0d cnt=%0d", imem_addr, cycle_cnt);
    check_state("lut_cleared", 0, 1, 0, 1);

    // Small build: PC wraps 15 -> 0, 4-bit counter saturates at 15.
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      $display("small cycle %0d: addr=%0d cnt=%0d valid=%0d", k, addr1, cnt1, valid1);
      chk($sformatf("small_addr%0d", k), 32'(addr1), 32'(k % 16));
      chk($sformatf("small_cnt%0d", k), 32'(cnt1), 32'((k > 15) ? 15 : k));
    end
    chk("small_valid", 32'(valid1), 32'd1);
    chk("small_done", 32'(done1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
